cfg_frame_loader: RTL and testbench

Serial configuration loader for the logic-cell array. Hunts for a sync byte in a bit-serial configuration stream, then deserializes one cell address and one LUT configuration word. It issues a single-cycle parallel write to the addressed cell's configuration register. It sits between the external bitstream source and the mux-based logic cells, and is the write end of the cell-configuration interface.

---
 rtl/cfg_loader_pkg.sv | 33 +++
 rtl/cfg_shift_reg.sv | 24 ++
 rtl/cfg_frame_loader.sv | 157 +++++++++++++++
 tb/tb_cfg_frame_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the serial configuration frame loader.
// Optional parity stage is selected with the CFG_FRAME_PARITY_EN macro.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int          SYNC_W         = 8;
  localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;
  localparam int          ADDR_W_DEFAULT = 4;
  localparam int          CFG_W_DEFAULT  = 16;

`ifdef CFG_FRAME_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Accepted bits per frame, excluding the WRITE cycle.
  function automatic int frame_bits(input int addr_w, input int cfg_w);
    return SYNC_W + addr_w + cfg_w + PAR_BITS;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// MSB-first shift register with enable and synchronous clear.
// Clear has priority over shifting; async active-low reset to zero.
module cfg_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Bit-serial configuration frame loader: sync hunt, address, LUT word, cell write.
// Define CFG_FRAME_PARITY_EN to add a trailing parity bit check with frame_err.
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEFAULT,
  parameter int         CFG_W  = CFG_W_DEFAULT,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_bit,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cell_we,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [CFG_W-1:0]  cell_cfg,
  output logic              frame_err,
  output logic [7:0]        frames_ok
);

  localparam int MAX_W = max_w(ADDR_W, CFG_W);
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SYNC_W-1:0]  sync_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CFG_W-1:0]   cfg_q;
  logic [SYNC_W-1:0]  sync_in;
  logic [CFG_W-1:0]   cfg_in;
  logic               ready_int;
  logic               accept;
  logic               sync_hit;

  assign ready_int = (state_reg != WRITE);
  // Gated by reset so the source sees "not ready" while the loader is held.
  assign cfg_ready = ready_int & rst;
  assign accept    = cfg_valid & ready_int;
  assign sync_in   = {sync_q[SYNC_W-2:0], cfg_bit};
  assign sync_hit  = (sync_in == SYNC);
  assign cfg_in    = {cfg_q[CFG_W-2:0], cfg_bit};

  cfg_shift_reg #(.W(SYNC_W)) u_sync_sr (
    .clk (clk),
    .rst (rst),
    .en  (accept && state_reg == HUNT),
    .clr (accept && state_reg == HUNT && sync_hit),
    .din (cfg_bit),
    .q   (sync_q)
  );

  cfg_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk (clk),
    .rst (rst),
    .en  (accept && state_reg == ADDR),
    .clr (1'b0),
    .din (cfg_bit),
    .q   (addr_q)
  );

  cfg_shift_reg #(.W(CFG_W)) u_cfg_sr (
    .clk (clk),
    .rst (rst),
    .en  (accept && state_reg == DATA),
    .clr (1'b0),
    .din (cfg_bit),
    .q   (cfg_q)
  );

`ifdef CFG_FRAME_PARITY_EN
  logic par_reg;
  logic bad_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_reg <= 1'b0;
    end else if (state_reg == HUNT) begin
      par_reg <= 1'b0;
    end else if (accept && (state_reg == ADDR || state_reg == DATA)) begin
      par_reg <= par_reg ^ cfg_bit;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
`ifdef CFG_FRAME_PARITY_EN
    bad_par    = 1'b0;
`endif
    case (state_reg)
      HUNT:  if (accept && sync_hit) state_next = ADDR;
      ADDR:  if (accept && cnt_reg == ADDR_LAST) state_next = DATA;
`ifdef CFG_FRAME_PARITY_EN
      DATA:  if (accept && cnt_reg == DATA_LAST) state_next = PAR;
      PAR: begin
        if (accept) begin
          if (cfg_bit == par_reg) begin
            state_next = WRITE;
          end else begin
            state_next = HUNT;
            bad_par    = 1'b1;
          end
        end
      end
`else
      DATA:  if (accept && cnt_reg == DATA_LAST) state_next = WRITE;
`endif
      WRITE:   state_next = HUNT;
      default: state_next = HUNT;
    endcase

    // Position counter restarts on every state entry.
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (accept && (state_reg == ADDR || state_reg == DATA)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
      cell_we   <= 1'b0;
      cell_addr <= '0;
      cell_cfg  <= '0;
      frames_ok <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cell_we   <= (state_next == WRITE);
      if (state_next == WRITE) begin
        cell_addr <= addr_q;
        // Entering from DATA, the last payload bit is still on the input.
        cell_cfg  <= (state_reg == DATA) ? cfg_in : cfg_q;
        frames_ok <= frames_ok + 8'd1;
      end
    end
  end

`ifdef CFG_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_par;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Scoreboard bench for cfg_frame_loader: driver queues expected writes, monitor checks them.
// Parity-related vectors are compiled in only when CFG_FRAME_PARITY_EN is defined.
module tb_cfg_frame_loader;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic [7:0]  n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cell_we;
  logic [3:0]  cell_addr;
  logic [15:0] cell_cfg;
  logic        frame_err;
  logic [7:0]  frames_ok;

  exp_t exp_q[$];
  exp_t mon_e;
  int   err_pending = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_frames = 0;
  int   ready_low = 0;

  always #5 clk = ~clk;

  cfg_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cell_we   (cell_we),
    .cell_addr (cell_addr),
    .cell_cfg  (cell_cfg),
    .frame_err (frame_err),
    .frames_ok (frames_ok)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: sample just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      if (!cfg_ready) ready_low++;
      if (cell_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h cfg %0h, expected no write", cell_addr, cell_cfg);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(cell_addr), 32'(mon_e.a));
          chk("wr_cfg", 32'(cell_cfg), 32'(mon_e.d));
          chk("wr_frames_ok", 32'(frames_ok), 32'(mon_e.n));
          $display("write addr=%0h cfg=%04h frames_ok=%0d", cell_addr, cell_cfg, frames_ok);
        end
      end
      if (frame_err) begin
        n_cmp++;
        if (err_pending > 0) begin
          err_pending--;
          $display("frame_err pulse seen, frames_ok=%0d", frames_ok);
        end else begin
          n_bad++;
          $display("FAIL unexpected_frame_err: got 1, expected 0");
        end
      end
    end
  end

  // Offer one bit starting at a negedge; returns at the negedge after acceptance.
  task automatic send_bit(input logic b, input int gap);
    int guard;
    cfg_valid = 1'b0;
    repeat (gap) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    guard     = 0;
    while (!cfg_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) chk("ready_timeout", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 0);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [15:0] d,
                            input bit good, input int gstep);
    logic [27:0] f;
    logic        p;
    f = {8'hA5, a, d};
    p = ^{a, d};
`ifndef CFG_FRAME_PARITY_EN
    good = 1'b1;
`endif
    if (good) begin
      exp_frames++;
      exp_q.push_back({a, d, 8'(exp_frames)});
    end else begin
      err_pending++;
    end
    for (int i = 27; i >= 0; i--) send_bit(f[i], (gstep != 0) ? ((i * gstep) % 6) : 0);
`ifdef CFG_FRAME_PARITY_EN
    send_bit(good ? p : ~p, 0);
`endif
    if (good) begin
      chk("we_latency", 32'(cell_we), 32'd1);
    end else begin
      chk("err_latency", 32'(frame_err), 32'd1);
      chk("err_no_we", 32'(cell_we), 32'd0);
      chk("err_frames_ok", 32'(frames_ok), 32'(exp_frames % 256));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_we"}, 32'(cell_we), 32'd0);
    chk({tag, "_addr"}, 32'(cell_addr), 32'd0);
    chk({tag, "_cfg"}, 32'(cell_cfg), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_frames_ok"}, 32'(frames_ok), 32'd0);
  endtask

  initial begin
    logic [3:0]  a4;
    logic [15:0] d16;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);

    send_frame(4'h3, 16'hBEEF, 1'b1, 0);
    send_frame(4'h3, 16'hBEEF, 1'b1, 1);

`ifdef CFG_FRAME_PARITY_EN
    send_frame(4'h3, 16'hBEEF, 1'b0, 0);
    send_frame(4'hF, 16'h0001, 1'b1, 0);
`endif

    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(4'h7, 16'h1234, 1'b1, 0);

    // Partial frame cut by reset during DATA.
    send_byte(8'hA5);
    a4 = 4'h9;
    d16 = 16'hF0F0;
    for (int i = 3; i >= 0; i--) send_bit(a4[i], 0);
    for (int i = 15; i >= 11; i--) send_bit(d16[i], 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 0;
    @(negedge clk);
    chk("midrst_ready_release", 32'(cfg_ready), 32'd1);
    chk("midrst_no_we", 32'(cell_we), 32'd0);
    send_frame(4'hC, 16'hA55A, 1'b1, 0);

    // Wrap run: 256 back-to-back frames from a fresh reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 0;
    @(negedge clk);
    ready_low = 0;
    for (int i = 0; i < 256; i++) begin
      send_frame(4'(i), 16'(i * 257) ^ 16'h3C3C, 1'b1, 0);
    end
    repeat (2) @(negedge clk);
    chk("wrap_frames_ok", 32'(frames_ok), 32'd0);
    chk("ready_low_per_frame", 32'(ready_low), 32'd256);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("pending_errs", 32'(err_pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
